// File: rtl/waveform_cfg_sequencer.sv
// AXI4-Lite master that writes a NUM_REGS x 32b register bank from a parallel config
// word and optionally reads every register back to verify it.
module waveform_cfg_sequencer #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 4,
   parameter int BASE_ADDR = 0,
   parameter int TIMEOUT   = 255,
   parameter int VERIFY    = 1,
   localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NUM_REGS*DATA_W-1:0]   cfg_data,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [2:0]                   err_code,
   output logic [IDX_W-1:0]             err_index,
   output logic [ADDR_W-1:0]            m_axi_awaddr,
   output logic [2:0]                   m_axi_awprot,
   output logic                         m_axi_awvalid,
   input  logic                         m_axi_awready,
   output logic [DATA_W-1:0]            m_axi_wdata,
   output logic [3:0]                   m_axi_wstrb,
   output logic                         m_axi_wvalid,
   input  logic                         m_axi_wready,
   input  logic [1:0]                   m_axi_bresp,
   input  logic                         m_axi_bvalid,
   output logic                         m_axi_bready,
   output logic [ADDR_W-1:0]            m_axi_araddr,
   output logic [2:0]                   m_axi_arprot,
   output logic                         m_axi_arvalid,
   input  logic                         m_axi_arready,
   input  logic [DATA_W-1:0]            m_axi_rdata,
   input  logic [1:0]                   m_axi_rresp,
   input  logic                         m_axi_rvalid,
   output logic                         m_axi_rready
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [15:0]      TO_LIM   = 16'(TIMEOUT - 1);

   state_t                       state;
   logic [IDX_W-1:0]             idx;
   logic [15:0]                  wait_cnt;
   logic [NUM_REGS*DATA_W-1:0]   cfg_q;

   logic aw_fire, w_fire, b_fire, ar_fire, r_fire, wr_both, expired;
   logic fault_now;
   logic [2:0] fault_code;
   logic [IDX_W-1:0] nxt_idx;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
      return ADDR_W'(32'(BASE_ADDR) + (32'(i) << 2));
   endfunction

   function automatic logic [DATA_W-1:0] word_of(input logic [NUM_REGS*DATA_W-1:0] v,
                                                 input logic [IDX_W-1:0] i);
      return v[DATA_W*int'(i) +: DATA_W];
   endfunction

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = 4'hF;

   assign aw_fire = m_axi_awvalid & m_axi_awready;
   assign w_fire  = m_axi_wvalid  & m_axi_wready;
   assign b_fire  = m_axi_bvalid  & m_axi_bready;
   assign ar_fire = m_axi_arvalid & m_axi_arready;
   assign r_fire  = m_axi_rvalid  & m_axi_rready;
   // An already-dropped valid counts as a completed handshake for that channel.
   assign wr_both = (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);
   assign expired = (wait_cnt == TO_LIM);
   assign nxt_idx = idx + 1'b1;

   always_comb begin
      fault_now  = 1'b0;
      fault_code = 3'b000;
      case (state)
         WR_REQ:
            if (!wr_both && !aw_fire && !w_fire && expired) begin
               fault_now = 1'b1; fault_code = 3'b100;
            end
         WR_RESP:
            if (b_fire) begin
               if (m_axi_bresp != 2'b00) begin fault_now = 1'b1; fault_code = 3'b001; end
            end else if (expired) begin
               fault_now = 1'b1; fault_code = 3'b100;
            end
         RD_REQ:
            if (!ar_fire && expired) begin fault_now = 1'b1; fault_code = 3'b100; end
         RD_RESP:
            if (r_fire) begin
               if (m_axi_rresp != 2'b00) begin
                  fault_now = 1'b1; fault_code = 3'b010;
               end else if (m_axi_rdata != word_of(cfg_q, idx)) begin
                  fault_now = 1'b1; fault_code = 3'b011;
               end
            end else if (expired) begin
               fault_now = 1'b1; fault_code = 3'b100;
            end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;  idx <= '0;  wait_cnt <= '0;  cfg_q <= '0;
         busy <= 1'b0;  done <= 1'b0;  error <= 1'b0;  err_code <= '0;  err_index <= '0;
         m_axi_awaddr <= '0;  m_axi_awvalid <= 1'b0;  m_axi_wdata <= '0;  m_axi_wvalid <= 1'b0;
         m_axi_bready <= 1'b0;  m_axi_araddr <= '0;  m_axi_arvalid <= 1'b0;  m_axi_rready <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fault_now) begin
            error <= 1'b1;  err_code <= fault_code;  err_index <= idx;
            m_axi_awvalid <= 1'b0;  m_axi_wvalid <= 1'b0;  m_axi_bready <= 1'b0;
            m_axi_arvalid <= 1'b0;  m_axi_rready <= 1'b0;
            busy <= 1'b0;  done <= 1'b1;  state <= FINISH;
         end else begin
            case (state)
               IDLE:
                  if (start) begin
                     cfg_q <= cfg_data;  idx <= '0;
                     error <= 1'b0;  err_code <= '0;  err_index <= '0;
                     busy <= 1'b1;  wait_cnt <= '0;
                     m_axi_awaddr <= addr_of('0);  m_axi_wdata <= word_of(cfg_data, '0);
                     m_axi_awvalid <= 1'b1;  m_axi_wvalid <= 1'b1;
                     state <= WR_REQ;
                  end
               WR_REQ:
                  if (wr_both) begin
                     m_axi_awvalid <= 1'b0;  m_axi_wvalid <= 1'b0;  m_axi_bready <= 1'b1;
                     wait_cnt <= '0;  state <= WR_RESP;
                  end else if (aw_fire || w_fire) begin
                     if (aw_fire) m_axi_awvalid <= 1'b0;
                     if (w_fire)  m_axi_wvalid  <= 1'b0;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + 16'd1;
                  end
               WR_RESP:
                  if (b_fire) begin
                     m_axi_bready <= 1'b0;  wait_cnt <= '0;
                     if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (VERIFY != 0) begin
                           m_axi_araddr <= addr_of('0);  m_axi_arvalid <= 1'b1;  state <= RD_REQ;
                        end else begin
                           busy <= 1'b0;  done <= 1'b1;  state <= FINISH;
                        end
                     end else begin
                        idx <= nxt_idx;
                        m_axi_awaddr <= addr_of(nxt_idx);  m_axi_wdata <= word_of(cfg_q, nxt_idx);
                        m_axi_awvalid <= 1'b1;  m_axi_wvalid <= 1'b1;  state <= WR_REQ;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + 16'd1;
                  end
               RD_REQ:
                  if (ar_fire) begin
                     m_axi_arvalid <= 1'b0;  m_axi_rready <= 1'b1;  wait_cnt <= '0;  state <= RD_RESP;
                  end else begin
                     wait_cnt <= wait_cnt + 16'd1;
                  end
               RD_RESP:
                  if (r_fire) begin
                     m_axi_rready <= 1'b0;  wait_cnt <= '0;
                     if (idx == LAST_IDX) begin
                        busy <= 1'b0;  done <= 1'b1;  state <= FINISH;
                     end else begin
                        idx <= nxt_idx;
                        m_axi_araddr <= addr_of(nxt_idx);  m_axi_arvalid <= 1'b1;  state <= RD_REQ;
                     end
                  end else begin
                     wait_cnt <= wait_cnt + 16'd1;
                  end
               FINISH:
                  state <= IDLE;
               default:
                  state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_waveform_cfg_sequencer.sv
// Scoreboard bench: a reactive AXI4-Lite slave with per-register delays and fault
// injection, a transaction-level reference model, and a monitor that checks every handshake.
module tb_waveform_cfg_sequencer;
   localparam int NR = 4;
   localparam int TO = 8;

   logic clock = 1'b0, reset = 1'b1, start = 1'b0;
   logic [NR*32-1:0] cfg_data = '0;
   logic busy, done, error;
   logic [2:0] err_code;
   logic [1:0] err_index;
   logic [3:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0] m_axi_awprot, m_axi_arprot;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0] m_axi_wstrb;
   logic [1:0] m_axi_bresp, m_axi_rresp;
   logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

   always #5 clock = ~clock;

   waveform_cfg_sequencer #(.ADDR_W(4), .DATA_W(32), .NUM_REGS(NR), .BASE_ADDR(0),
                            .TIMEOUT(TO), .VERIFY(1)) dut (
      .clock(clock), .reset(reset), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready));

   typedef struct { logic [3:0] addr; int cycles; bit gone; } aq_t;
   typedef struct { logic [31:0] data; int cycles; } wq_t;
   typedef struct { bit err; logic [2:0] code; int idx; int lat; } dq_t;

   aq_t exp_aw[$], exp_ar[$];
   wq_t exp_w[$];
   dq_t exp_done[$];

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, st_cyc = 0;
   logic [31:0] cfg[NR];
   int aw_dly[NR], w_dly[NR], ar_dly[NR];
   int bad_w, bad_rresp, bad_rdata, stuck_ar;
   logic [31:0] mem[NR];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin @(posedge clock); cyc++; end

   // Reactive slave: readies and responses change #1 after the clock edge.
   initial begin
      int awc, wc, arc;
      bit aw_acc, w_acc, awf, wf, bf, arf, rf;
      logic [3:0] wa, ra;
      logic [31:0] wd;
      awc = 0; wc = 0; arc = 0; aw_acc = 0; w_acc = 0; wa = '0; ra = '0; wd = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      forever begin
         @(negedge clock);
         awf = m_axi_awvalid && m_axi_awready;  wf = m_axi_wvalid && m_axi_wready;
         bf = m_axi_bvalid && m_axi_bready;  arf = m_axi_arvalid && m_axi_arready;
         rf = m_axi_rvalid && m_axi_rready;
         if (awf) wa = m_axi_awaddr;
         if (wf)  wd = m_axi_wdata;
         if (arf) ra = m_axi_araddr;
         @(posedge clock); #1;
         if (reset) begin
            awc = 0; wc = 0; arc = 0; aw_acc = 0; w_acc = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
            continue;
         end
         if (awf) aw_acc = 1;
         if (wf)  w_acc = 1;
         if (bf)  m_axi_bvalid = 0;
         if (aw_acc && w_acc) begin
            mem[wa[3:2]] = wd;
            m_axi_bresp = (int'(wa[3:2]) == bad_w) ? 2'b10 : 2'b00;
            m_axi_bvalid = 1; aw_acc = 0; w_acc = 0;
         end
         if (m_axi_awvalid) begin
            m_axi_awready = (awc >= aw_dly[m_axi_awaddr[3:2]]); awc++;
         end else begin m_axi_awready = 0; awc = 0; end
         if (m_axi_wvalid) begin
            m_axi_wready = (wc >= w_dly[m_axi_awaddr[3:2]]); wc++;
         end else begin m_axi_wready = 0; wc = 0; end
         if (rf) m_axi_rvalid = 0;
         if (arf) begin
            m_axi_rvalid = 1;
            m_axi_rdata = (int'(ra[3:2]) == bad_rdata) ? 32'hDEAD : mem[ra[3:2]];
            m_axi_rresp = (int'(ra[3:2]) == bad_rresp) ? 2'b10 : 2'b00;
         end
         if (!m_axi_arvalid) begin m_axi_arready = 0; arc = 0; end
         else if (int'(m_axi_araddr[3:2]) == stuck_ar) m_axi_arready = 0;
         else begin m_axi_arready = (arc >= ar_dly[m_axi_araddr[3:2]]); arc++; end
      end
   end

   // Monitor: pops the scoreboard on every handshake, abandoned request and done pulse.
   initial begin
      int aw_hi, w_hi, ar_hi;
      aq_t a; wq_t w; dq_t d;
      aw_hi = 0; w_hi = 0; ar_hi = 0;
      forever begin
         @(negedge clock);
         if (reset) begin aw_hi = 0; w_hi = 0; ar_hi = 0; continue; end
         if (m_axi_awvalid) begin
            aw_hi++;
            if (m_axi_awready) begin
               check("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
               if (exp_aw.size() != 0) begin
                  a = exp_aw.pop_front();
                  check("awaddr", 64'(m_axi_awaddr), 64'(a.addr));
                  check("aw_cycles", 64'(aw_hi), 64'(a.cycles));
                  check("awprot", 64'(m_axi_awprot), 64'd0);
               end
               aw_hi = 0;
            end
         end
         if (m_axi_wvalid) begin
            w_hi++;
            if (m_axi_wready) begin
               check("w_expected", 64'(exp_w.size() != 0), 64'd1);
               if (exp_w.size() != 0) begin
                  w = exp_w.pop_front();
                  check("wdata", 64'(m_axi_wdata), 64'(w.data));
                  check("w_cycles", 64'(w_hi), 64'(w.cycles));
                  check("wstrb", 64'(m_axi_wstrb), 64'hF);
               end
               w_hi = 0;
            end
         end
         if (m_axi_arvalid) begin
            ar_hi++;
            if (m_axi_arready) begin
               check("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
               if (exp_ar.size() != 0) begin
                  a = exp_ar.pop_front();
                  check("araddr", 64'(m_axi_araddr), 64'(a.addr));
                  check("ar_cycles", 64'(ar_hi), 64'(a.cycles));
                  check("ar_accepted", 64'd1, 64'(!a.gone));
                  check("arprot", 64'(m_axi_arprot), 64'd0);
               end
               ar_hi = 0;
            end
         end else if (ar_hi > 0) begin
            check("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
            if (exp_ar.size() != 0) begin
               a = exp_ar.pop_front();
               check("ar_abandoned", 64'd1, 64'(a.gone));
               check("ar_timeout_cycles", 64'(ar_hi), 64'(a.cycles));
            end
            ar_hi = 0;
         end
         if (done) begin
            check("done_expected", 64'(exp_done.size() != 0), 64'd1);
            if (exp_done.size() != 0) begin
               d = exp_done.pop_front();
               check("error", 64'(error), 64'(d.err));
               check("err_code", 64'(err_code), 64'(d.code));
               check("err_index", 64'(err_index), 64'(d.idx));
               check("busy_at_done", 64'(busy), 64'd0);
               if (d.lat >= 0) check("done_latency", 64'(cyc - st_cyc), 64'(d.lat));
            end
         end
      end
   end

   // Transaction-level reference: each write costs max(aw,w delay)+2 cycles, each read
   // its ar delay+2, a stuck AR costs TO cycles; the first fault ends the sequence.
   task automatic model();
      int lat; aq_t a; wq_t w; dq_t d;
      lat = 1;
      for (int k = 0; k < NR; k++) begin
         a.addr = 4'(4 * k); a.cycles = aw_dly[k] + 1; a.gone = 0; exp_aw.push_back(a);
         w.data = cfg[k]; w.cycles = w_dly[k] + 1; exp_w.push_back(w);
         lat += ((aw_dly[k] > w_dly[k]) ? aw_dly[k] : w_dly[k]) + 2;
         if (k == bad_w) begin d = '{1'b1, 3'b001, k, lat}; exp_done.push_back(d); return; end
      end
      for (int k = 0; k < NR; k++) begin
         a.addr = 4'(4 * k);
         if (k == stuck_ar) begin
            a.cycles = TO; a.gone = 1; exp_ar.push_back(a); lat += TO;
            d = '{1'b1, 3'b100, k, lat}; exp_done.push_back(d); return;
         end
         a.cycles = ar_dly[k] + 1; a.gone = 0; exp_ar.push_back(a);
         lat += ar_dly[k] + 2;
         if (k == bad_rresp) begin d = '{1'b1, 3'b010, k, lat}; exp_done.push_back(d); return; end
         if (k == bad_rdata) begin d = '{1'b1, 3'b011, k, lat}; exp_done.push_back(d); return; end
      end
      d = '{1'b0, 3'b000, 0, lat}; exp_done.push_back(d);
   endtask

   task automatic clear_cfg();
      for (int k = 0; k < NR; k++) begin aw_dly[k] = 0; w_dly[k] = 0; ar_dly[k] = 0; end
      bad_w = -1; bad_rresp = -1; bad_rdata = -1; stuck_ar = -1;
   endtask

   task automatic pulse_start();
      for (int k = 0; k < NR; k++) cfg_data[32*k +: 32] = cfg[k];
      @(posedge clock); #1; start = 1; st_cyc = cyc;
      @(posedge clock); #1; start = 0;
   endtask

   task automatic run_case(input bit extra_start);
      bit exp_err;
      model();
      exp_err = exp_done[0].err;
      pulse_start();
      if (extra_start) begin
         repeat (3) @(posedge clock);
         #1; start = 1; @(posedge clock); #1; start = 0;
      end
      for (int i = 0; i < 300 && exp_done.size() != 0; i++) @(negedge clock);
      check("done_seen", 64'(exp_done.size()), 64'd0);
      repeat (3) @(negedge clock);
      check("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);
      check("error_sticky", 64'(error), 64'(exp_err));
      exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done.delete();
   endtask

   initial begin
      int sel;
      clear_cfg();
      for (int k = 0; k < NR; k++) mem[k] = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'({error, err_code, err_index}), 64'd0);
      check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
      check("rst_addr_data", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata}), 64'd0);
      @(posedge clock); #1; reset = 0;

      cfg = '{32'h4, 32'h3, 32'h2, 32'h1};
      run_case(0);                                        // ideal slave, latency 17
      clear_cfg(); bad_w = 2; run_case(0);                // SLVERR on write to 0x8
      clear_cfg(); bad_rdata = 1; run_case(0);            // bad readback of reg1
      clear_cfg(); for (int k = 0; k < NR; k++) aw_dly[k] = 3; run_case(0);
      clear_cfg(); stuck_ar = 0; run_case(0);             // AR timeout
      clear_cfg(); cfg = '{32'hA5A5_0001, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678}; run_case(1);

      // Reset while the first write request is outstanding
      clear_cfg();
      for (int k = 0; k < NR; k++) begin aw_dly[k] = 3; w_dly[k] = 3; end
      pulse_start();
      for (int i = 0; i < 20 && !m_axi_awvalid; i++) @(negedge clock);
      check("awvalid_before_reset", 64'(m_axi_awvalid), 64'd1);
      @(posedge clock); #2; reset = 1;
      @(posedge clock); @(negedge clock);
      check("midrst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      @(posedge clock); #1; reset = 0;
      clear_cfg(); cfg = '{32'h4, 32'h3, 32'h2, 32'h1}; run_case(0);

      for (int n = 0; n < 24; n++) begin
         clear_cfg();
         for (int k = 0; k < NR; k++) begin
            cfg[k] = $urandom;
            aw_dly[k] = $urandom_range(0, 3); w_dly[k] = $urandom_range(0, 3); ar_dly[k] = $urandom_range(0, 3);
         end
         sel = $urandom_range(0, 7);
         case (sel)
            0: bad_w = $urandom_range(0, NR - 1);
            1: bad_rresp = $urandom_range(0, NR - 1);
            2: bad_rdata = $urandom_range(0, NR - 1);
            3: stuck_ar = $urandom_range(0, NR - 1);
            default: ;
         endcase
         run_case(n % 5 == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
